shiftreg_sweep_ctrl: RTL and testbench

Sequencer for the bouncing one-hot shift register. It generates the register's step enable at a programmable rate and counts the register's terminal-count (TC) pulses as completed sweeps. It stops after a programmed number of sweeps, or runs continuously, and supports start/stop/pause commands. It sits between the register-bank command interface and the shift register's `ena`/`TC` pins.

---
 rtl/shiftreg_pkg.sv | 14 +
 rtl/step_prescaler.sv | 37 +++
 rtl/shiftreg_sweep_ctrl.sv | 120 ++++++++++++
 tb/tb_shiftreg_sweep_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared types and default widths for the bouncing shift-register sequencer.
package shiftreg_pkg;

    localparam int DEF_DIV_WIDTH     = 16;
    localparam int DEF_COUNTER_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/step_prescaler.sv
// Programmable step-rate prescaler.
// Counts 0..r_max and ticks on the terminal value. A load latches a new
// period and restarts the count. A clear restarts the count but keeps the
// period. With i_en low the count holds.
module step_prescaler #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [DIV_WIDTH-1:0] i_max,
    input  logic                 i_clr,
    input  logic                 i_en,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_max;
    logic [DIV_WIDTH-1:0] r_cnt;

    assign o_tick = (r_cnt == r_max);

    // Period latch and wrapping counter; load beats clear beats count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_max <= i_max;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/shiftreg_sweep_ctrl.sv
// Sweep sequencer for the bouncing one-hot shift register.
// Generates the step enable at a programmable rate. Counts TC pulses as
// completed sweeps. Ends a run after a programmed sweep count, or on stop.
// A sweep count of 0 means the sequencer runs until stopped.
module shiftreg_sweep_ctrl
    import shiftreg_pkg::*;
#(
    parameter int DIV_WIDTH     = DEF_DIV_WIDTH,
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic [DIV_WIDTH-1:0]     cfg_div,
    input  logic [COUNTER_WIDTH-1:0] cfg_sweeps,
    input  logic                     tc,
    output logic                     sr_ena,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic [COUNTER_WIDTH-1:0] sweep_cnt
);

    state_t                   r_state;
    logic [COUNTER_WIDTH-1:0] r_sweeps_q;
    logic [COUNTER_WIDTH-1:0] r_sweep_cnt;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_aborted;

    logic                     w_start_ok;
    logic                     w_active;
    logic                     w_tick;
    logic                     w_final_tc;
    logic                     w_pre_en;
    logic [COUNTER_WIDTH-1:0] w_cnt_inc;

    assign w_start_ok = (r_state == IDLE) && start && !stop;
    assign w_active   = (r_state == RUN) || (r_state == PAUSE);
    assign w_cnt_inc  = r_sweep_cnt + COUNTER_WIDTH'(1);
    // The last expected TC closes the run. The step that would start
    // another sweep is suppressed in that cycle.
    assign w_final_tc = w_active && tc && (r_sweeps_q != '0) && (w_cnt_inc == r_sweeps_q);
    // The prescaler advances only while actually stepping. Pause freezes it
    // so that stepping resumes with the phase it had before the pause.
    assign w_pre_en   = (r_state == RUN) && !pause;

    assign sr_ena    = (r_state == RUN) && !pause && w_tick && !w_final_tc;
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign sweep_cnt = r_sweep_cnt;

    step_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_start_ok),
        .i_max  (cfg_div),
        .i_clr  (w_active && stop),
        .i_en   (w_pre_en),
        .o_tick (w_tick)
    );

    // Run-control FSM with sweep counter and registered status/pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sweeps_q  <= '0;
            r_sweep_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_state     <= RUN;
                        r_sweeps_q  <= cfg_sweeps;
                        r_sweep_cnt <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                RUN, PAUSE: begin
                    if (stop) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else begin
                        if (tc) begin
                            r_sweep_cnt <= w_cnt_inc;
                        end
                        if (w_final_tc) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (pause) begin
                            r_state <= PAUSE;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_sweep_ctrl.sv
// Directed bench for shiftreg_sweep_ctrl. Cycle k = k-th cycle after the
// start command cycle. A small TC model raises tc for one cycle after
// every 8th sr_ena when enabled.
module tb_shiftreg_sweep_ctrl;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          tc = 1'b0;
    logic [DW-1:0] cfg_div = '0;
    logic [CW-1:0] cfg_sweeps = '0;
    logic          sr_ena;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [CW-1:0] sweep_cnt;

    int total = 0;
    int bad   = 0;
    bit model_on = 1'b0;
    int ena_cnt  = 0;
    bit tc_pend  = 1'b0;

    always #5 clk = ~clk;

    shiftreg_sweep_ctrl #(
        .DIV_WIDTH     (DW),
        .COUNTER_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .cfg_div    (cfg_div),
        .cfg_sweeps (cfg_sweeps),
        .tc         (tc),
        .sr_ena     (sr_ena),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .sweep_cnt  (sweep_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},    busy,    1'b0);
        chk({tag, "_ena"},     sr_ena,  1'b0);
        chk({tag, "_done"},    done,    1'b0);
        chk({tag, "_aborted"}, aborted, 1'b0);
    endtask

    // One clock: feed the TC model, clock, apply the model tc, drop 1-cycle commands.
    task automatic cyc();
        #1;
        if (model_on && sr_ena === 1'b1) begin
            ena_cnt++;
            if (ena_cnt == 8) begin
                ena_cnt = 0;
                tc_pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        tc      = tc_pend;
        tc_pend = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        chk_idle("rst");
        chk("rst_cnt", sweep_cnt, 8'd0);
        rst = 1'b0;
        cyc();

        // Reset held 3 cycles in the middle of a run
        cfg_div = 16'd2; cfg_sweeps = 8'd4; start = 1'b1;
        cyc();
        tc = 1'b1;
        cyc();
        chk("s1_busy", busy, 1'b1);
        chk("s1_cnt", sweep_cnt, 8'd1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_idle("s1_inrst");
            chk("s1_inrst_cnt", sweep_cnt, 8'd0);
        end
        rst = 1'b0;
        cyc();
        chk_idle("s1_post");
        chk("s1_post_cnt", sweep_cnt, 8'd0);

        // div=3, sweeps=2: steps at k=4,8,..,64; TC at k=33 and k=65; DONE at k=66
        cfg_div = 16'd3; cfg_sweeps = 8'd2; start = 1'b1;
        ena_cnt = 0; model_on = 1'b1;
        cyc();
        for (int k = 1; k <= 70; k++) begin
            chk("s2_ena",  sr_ena, (k % 4 == 0) && (k <= 64));
            chk("s2_busy", busy,   k <= 65);
            chk("s2_done", done,   k == 66);
            chk("s2_cnt",  sweep_cnt, (k < 34) ? 32'd0 : (k < 66) ? 32'd1 : 32'd2);
            cyc();
        end
        model_on = 1'b0;

        // Continuous, div=0: step every cycle; TC at k=8s+1; count visible at k=8s+2
        cfg_div = 16'd0; cfg_sweeps = 8'd0; start = 1'b1;
        ena_cnt = 0; model_on = 1'b1;
        cyc();
        for (int k = 1; k <= 2402; k++) begin
            chk("s3_ena",  sr_ena, 1'b1);
            chk("s3_done", done,   1'b0);
            if (k == 2049) chk("s3_cnt_255", sweep_cnt, 8'd255);
            if (k == 2050) chk("s3_cnt_wrap", sweep_cnt, 8'd0);
            if (k == 2402) chk("s3_cnt_end", sweep_cnt, 8'd44);
            if (k < 2402) cyc();
        end
        model_on = 1'b0;
        stop = 1'b1;
        cyc();
        chk("s3_abort", aborted, 1'b1);
        chk("s3_abort_busy", busy, 1'b0);
        chk("s3_abort_cnt", sweep_cnt, 8'd44);
        cyc();
        chk("s3_abort_pulse", aborted, 1'b0);

        // div=4: prescaler is 2 at k=3; pause k=3..12; RUN resumes at k=14, step at k=16
        cfg_div = 16'd4; cfg_sweeps = 8'd0; start = 1'b1;
        cyc();
        for (int k = 1; k <= 2; k++) begin
            chk("s4_pre_ena", sr_ena, 1'b0);
            cyc();
        end
        pause = 1'b1;
        #1;
        for (int k = 3; k <= 12; k++) begin
            chk("s4_pause_ena", sr_ena, 1'b0);
            chk("s4_pause_busy", busy, 1'b1);
            cyc();
        end
        pause = 1'b0;
        #1;
        for (int k = 13; k <= 16; k++) begin
            chk("s4_resume_ena", sr_ena, k == 16);
            cyc();
        end
        stop = 1'b1;
        cyc();
        chk("s4_abort", aborted, 1'b1);
        cyc();

        // start+stop together in IDLE, then stop mid-run with sweep_cnt=1
        start = 1'b1; stop = 1'b1;
        cyc();
        chk("s5_ss_busy", busy, 1'b0);
        chk("s5_ss_abort", aborted, 1'b0);
        cyc();
        chk("s5_ss_busy2", busy, 1'b0);
        cfg_div = 16'd1; cfg_sweeps = 8'd5; start = 1'b1;
        cyc();
        chk("s5_busy", busy, 1'b1);
        chk("s5_cnt0", sweep_cnt, 8'd0);
        tc = 1'b1;
        cyc();
        chk("s5_cnt1", sweep_cnt, 8'd1);
        stop = 1'b1;
        cyc();
        chk("s5_abort", aborted, 1'b1);
        chk("s5_abort_busy", busy, 1'b0);
        chk("s5_abort_cnt", sweep_cnt, 8'd1);
        cyc();
        chk("s5_abort_pulse", aborted, 1'b0);
        chk("s5_hold_cnt", sweep_cnt, 8'd1);

        // tc in IDLE ignored
        tc = 1'b1;
        cyc();
        chk("s6_idle_tc_cnt", sweep_cnt, 8'd1);
        chk("s6_idle_tc_busy", busy, 1'b0);

        // div=1, sweeps=2; restart attempt at k=1 with other cfg is ignored
        cfg_div = 16'd1; cfg_sweeps = 8'd2; start = 1'b1;
        cyc();
        chk("s6_cnt_clr", sweep_cnt, 8'd0);
        chk("s6_k1_ena", sr_ena, 1'b0);
        start = 1'b1; cfg_div = 16'd7; cfg_sweeps = 8'd1;
        cyc();
        chk("s6_k2_ena", sr_ena, 1'b1);
        cyc();
        chk("s6_k3_ena", sr_ena, 1'b0);
        cyc();
        chk("s6_k4_ena", sr_ena, 1'b1);
        tc = 1'b1;
        cyc();
        chk("s6_k5_busy", busy, 1'b1);
        chk("s6_k5_cnt", sweep_cnt, 8'd1);
        chk("s6_k5_ena", sr_ena, 1'b0);
        cyc();
        tc = 1'b1;
        #1;
        chk("s6_final_ena", sr_ena, 1'b0);
        cyc();
        chk("s6_done", done, 1'b1);
        chk("s6_done_busy", busy, 1'b0);
        chk("s6_done_cnt", sweep_cnt, 8'd2);
        chk("s6_done_abort", aborted, 1'b0);
        stop = 1'b1;
        cyc();
        chk("s6_post_done", done, 1'b0);
        chk("s6_post_abort", aborted, 1'b0);
        chk("s6_post_busy", busy, 1'b0);
        chk("s6_post_cnt", sweep_cnt, 8'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
